id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register plus operand-forwarding and load-use hazard logic; directly upstream of the EX-stage ALU.
- Captures decoded operands and control from ID each cycle.
- Resolves data hazards against the EX-stage and MEM-stage instructions.
- Presents registered a, b and aluc to the ALU, plus store data and writeback control to later stages.

Parameters:
- DATA_W, 32, operand/result width.
- REG_AW, 5, register index width.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_ra, id_rb  in  REG_AW  source register indices.
- id_qa, id_qb  in  DATA_W  register-file read data.
- id_imm  in  DATA_W  extended immediate.
- id_sa  in  5  shift amount.
- id_aluimm  in  1  b operand is the immediate.
- id_shift  in  1  shift op: a=rb value, b=sa.
- id_aluc  in  4  ALU opcode.
- id_rd  in  REG_AW  destination register.
- id_wreg, id_m2reg, id_wmem  in  1  writeback, load, store controls.
- ex_alu_s  in  DATA_W  current ALU result (EX forwarding source).
- mem_rd  in  REG_AW  MEM-stage destination register.
- mem_wreg, mem_m2reg  in  1  MEM-stage controls.
- mem_result  in  DATA_W  MEM-stage value (loaded data when mem_m2reg=1).
- flush  in  1  squash the instruction entering EX (taken branch/jump).
- ex_valid  out  1  EX-stage valid.
- ex_a, ex_b  out  DATA_W  ALU operands.
- ex_aluc  out  4  ALU opcode.
- ex_store_data  out  DATA_W  forwarded rb value, for stores.
- ex_rd  out  REG_AW  EX-stage destination register.
- ex_wreg, ex_m2reg, ex_wmem  out  1  EX-stage controls.
- stall  out  1  combinational; ID and PC must hold this cycle.
- fwd_a_sel, fwd_b_sel  out  2  combinational forwarding select, for debug: 0=regfile, 1=EX, 2=MEM.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (async, active-high): all registered outputs 0. An all-zero state is a bubble (ex_valid=0, aluc=0000, wreg/m2reg/wmem=0). stall_count=0.
- Register r0 is never forwarded; it always reads as the regfile value.
- Source use:
  - ra is used when !id_shift.
  - rb is used when id_shift, or !id_aluimm, or id_wmem.
  - Unused sources never cause a stall.
- Forwarding, per used source, with priority EX > MEM > regfile:
  - EX hit: ex_valid & ex_wreg & !ex_m2reg & ex_rd==src & src!=0 selects ex_alu_s.
  - MEM hit: mem_wreg & mem_rd==src & src!=0 selects mem_result.
- Load-use stall: stall=1 when ex_valid & ex_wreg & ex_m2reg & ex_rd!=0 & ex_rd matches a used source, and id_valid=1.
- Operand mux (fa, fb = forwarded ra, rb values):
  - ex_a = id_shift ? fb : fa.
  - ex_b = id_shift ? {27'b0,id_sa} : id_aluimm ? id_imm : fb.
  - ex_store_data = fb.
- Next state on each clock edge:
  - If flush=1: load a bubble. flush overrides stall.
  - Else if stall=1: load a bubble; ID must re-present the same instruction next cycle.
  - Else: load the ID fields, with ex_valid=id_valid.
  - id_valid=0 loads a bubble regardless of its other fields.
- stall_count increments on each edge where stall=1 and flush=0, and saturates at all-ones.
- Latency: one cycle from ID capture to ALU inputs; forwarding adds no cycles. A load-use hazard costs exactly one bubble.
- Simultaneous EX and MEM hits on the same source: EX wins. Hits on ra and rb select independently.
- Reset asserted mid-stall: outputs go to bubble immediately; the stall drops because ex_valid=0.

Test Plan:
- Reset: assert reset with nonzero inputs → all ex_* outputs 0, stall=0, stall_count=0; remains so until the first edge after deassert.
- EX forward: EX holds add r3 (ex_alu_s=0x00000010); ID presents sub r5,r3,r4 with qa=0x1, qb=0x4 → fwd_a_sel=1; next edge ex_a=0x10, ex_b=0x4, ex_aluc=1000.
- Priority and r0: EX and MEM both write r3 (0x10 vs 0x20) → ex_a=0x10. An ID op with ra=0, while EX writes r0 with 0xFF → ex_a=id_qa, fwd_a_sel=0.
- Load-use:
  - EX is lw r2, ID is add r6,r2,r1 → stall=1; next edge bubble, stall_count=1.
  - After the load moves to MEM with mem_result=0xABCD, ID held → ex_a=0xABCD, fwd_a_sel=2.
- Shift/immediate: id_shift=1, rb=r7 (qb=0x3), sa=4, aluc=0001 → ex_a=0x3, ex_b=0x4; ra matches an EX load → no stall.
- Flush over stall: load-use condition plus flush=1 → bubble loaded, stall_count unchanged. Force stall for 2^CNT_W+3 cycles → stall_count holds at all-ones.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use stall.
// Ports: clock/reset; id_* decoded instruction from ID; ex_alu_s and
// mem_* forwarding sources; flush squashes the incoming instruction;
// ex_* registered ALU operands and controls; stall, fwd_a_sel,
// fwd_b_sel (0=regfile, 1=EX, 2=MEM) and a saturating stall_count.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_ra,
    input  logic [REG_AW-1:0] id_rb,
    input  logic [DATA_W-1:0] id_qa,
    input  logic [DATA_W-1:0] id_qb,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_sa,
    input  logic              id_aluimm,
    input  logic              id_shift,
    input  logic [3:0]        id_aluc,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wreg,
    input  logic              id_m2reg,
    input  logic              id_wmem,
    input  logic [DATA_W-1:0] ex_alu_s,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_wreg,
    input  logic              mem_m2reg,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              flush,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [3:0]        ex_aluc,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_wreg,
    output logic              ex_m2reg,
    output logic              ex_wmem,
    output logic              stall,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  stall_count
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [3:0]        aluc_q, aluc_d;
    logic [DATA_W-1:0] sd_q, sd_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              wreg_q, wreg_d;
    logic              m2reg_q, m2reg_d;
    logic              wmem_q, wmem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              use_a, use_b;
    logic              ex_fwd_ok, ex_load;
    logic [DATA_W-1:0] fa, fb;

    // mem_m2reg only tells the MEM stage what mem_result carries;
    // forwarding takes mem_result either way.
    logic              unused_mem_m2reg;
    assign unused_mem_m2reg = mem_m2reg;

    always_comb begin
        use_a     = !id_shift;
        use_b     = id_shift | !id_aluimm | id_wmem;
        // A load in EX has no data yet, so it cannot be forwarded.
        ex_fwd_ok = valid_q & wreg_q & !m2reg_q;
        ex_load   = valid_q & wreg_q & m2reg_q & (rd_q != '0);

        fwd_a_sel = 2'd0;
        fa        = id_qa;
        if (use_a && id_ra != '0) begin
            if (ex_fwd_ok && rd_q == id_ra) begin
                fwd_a_sel = 2'd1;
                fa        = ex_alu_s;
            end else if (mem_wreg && mem_rd == id_ra) begin
                fwd_a_sel = 2'd2;
                fa        = mem_result;
            end
        end

        fwd_b_sel = 2'd0;
        fb        = id_qb;
        if (use_b && id_rb != '0) begin
            if (ex_fwd_ok && rd_q == id_rb) begin
                fwd_b_sel = 2'd1;
                fb        = ex_alu_s;
            end else if (mem_wreg && mem_rd == id_rb) begin
                fwd_b_sel = 2'd2;
                fb        = mem_result;
            end
        end

        stall = id_valid & ex_load &
                ((use_a & (rd_q == id_ra)) | (use_b & (rd_q == id_rb)));

        valid_d = 1'b0;
        a_d     = '0;
        b_d     = '0;
        aluc_d  = '0;
        sd_d    = '0;
        rd_d    = '0;
        wreg_d  = 1'b0;
        m2reg_d = 1'b0;
        wmem_d  = 1'b0;
        if (!flush && !stall && id_valid) begin
            valid_d = 1'b1;
            a_d     = id_shift ? fb : fa;
            if (id_shift)
                b_d = {{(DATA_W-5){1'b0}}, id_sa};
            else if (id_aluimm)
                b_d = id_imm;
            else
                b_d = fb;
            aluc_d  = id_aluc;
            sd_d    = fb;
            rd_d    = id_rd;
            wreg_d  = id_wreg;
            m2reg_d = id_m2reg;
            wmem_d  = id_wmem;
        end

        cnt_d = cnt_q;
        if (stall && !flush && cnt_q != '1)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            aluc_q  <= '0;
            sd_q    <= '0;
            rd_q    <= '0;
            wreg_q  <= 1'b0;
            m2reg_q <= 1'b0;
            wmem_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            aluc_q  <= aluc_d;
            sd_q    <= sd_d;
            rd_q    <= rd_d;
            wreg_q  <= wreg_d;
            m2reg_q <= m2reg_d;
            wmem_q  <= wmem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_a          = a_q;
    assign ex_b          = b_q;
    assign ex_aluc       = aluc_q;
    assign ex_store_data = sd_q;
    assign ex_rd         = rd_q;
    assign ex_wreg       = wreg_q;
    assign ex_m2reg      = m2reg_q;
    assign ex_wmem       = wmem_q;
    assign stall_count   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard scenarios plus random traffic
// checked every cycle against a transaction-level model of the EX slot.
module tb_id_ex_stage;

    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_ra, id_rb, id_rd, id_sa;
    logic [31:0] id_qa, id_qb, id_imm;
    logic        id_aluimm, id_shift, id_wreg, id_m2reg, id_wmem;
    logic [3:0]  id_aluc;
    logic [31:0] ex_alu_s, mem_result;
    logic [4:0]  mem_rd;
    logic        mem_wreg, mem_m2reg, flush;
    logic        ex_valid, ex_wreg, ex_m2reg, ex_wmem, stall;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [3:0]  ex_aluc;
    logic [4:0]  ex_rd;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [CW-1:0] stall_count;

    id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_ra(id_ra), .id_rb(id_rb), .id_qa(id_qa), .id_qb(id_qb),
        .id_imm(id_imm), .id_sa(id_sa), .id_aluimm(id_aluimm),
        .id_shift(id_shift), .id_aluc(id_aluc), .id_rd(id_rd),
        .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem),
        .ex_alu_s(ex_alu_s), .mem_rd(mem_rd), .mem_wreg(mem_wreg),
        .mem_m2reg(mem_m2reg), .mem_result(mem_result), .flush(flush),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
        .ex_aluc(ex_aluc), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg),
        .ex_wmem(ex_wmem), .stall(stall), .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel), .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          v;
        bit   [31:0] a, b, sd;
        bit   [3:0]  aluc;
        bit   [4:0]  rd;
        bit          wreg, m2reg, wmem;
    } ex_t;

    ex_t m;
    int  cnt;
    int  npass = 0;
    int  ntot  = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit ra_used();
        return !id_shift;
    endfunction

    function automatic bit rb_used();
        return id_shift || !id_aluimm || id_wmem;
    endfunction

    // Source value as the EX stage should see it: newest producer wins.
    function automatic void fwd(input bit [4:0] src, input bit used,
                                input bit [31:0] q, output int sel,
                                output bit [31:0] val);
        sel = 0;
        val = q;
        if (!used || src == 0) return;
        if (m.v && m.wreg && !m.m2reg && m.rd == src) begin
            sel = 1;
            val = ex_alu_s;
        end else if (mem_wreg && mem_rd == src) begin
            sel = 2;
            val = mem_result;
        end
    endfunction

    task automatic check_regs();
        chk("ex_valid", ex_valid, m.v);
        chk("ex_a", ex_a, m.a);
        chk("ex_b", ex_b, m.b);
        chk("ex_aluc", ex_aluc, m.aluc);
        chk("ex_store_data", ex_store_data, m.sd);
        chk("ex_rd", ex_rd, m.rd);
        chk("ex_wreg", ex_wreg, m.wreg);
        chk("ex_m2reg", ex_m2reg, m.m2reg);
        chk("ex_wmem", ex_wmem, m.wmem);
        chk("stall_count", stall_count, cnt);
    endtask

    task automatic cycle();
        int        sa_e, sb_e;
        bit [31:0] fa, fb;
        bit        st, hit;
        ex_t       n;
        #1;
        fwd(id_ra, ra_used(), id_qa, sa_e, fa);
        fwd(id_rb, rb_used(), id_qb, sb_e, fb);
        hit = (ra_used() && m.rd == id_ra) || (rb_used() && m.rd == id_rb);
        st  = id_valid && m.v && m.wreg && m.m2reg && m.rd != 0 && hit;
        chk("stall", stall, st);
        chk("fwd_a_sel", fwd_a_sel, sa_e);
        chk("fwd_b_sel", fwd_b_sel, sb_e);
        n = '{default: 0};
        if (!flush && !st && id_valid) begin
            n.v     = 1;
            n.a     = id_shift ? fb : fa;
            n.b     = id_shift ? 32'(id_sa) : (id_aluimm ? id_imm : fb);
            n.sd    = fb;
            n.aluc  = id_aluc;
            n.rd    = id_rd;
            n.wreg  = id_wreg;
            n.m2reg = id_m2reg;
            n.wmem  = id_wmem;
        end
        @(posedge clock);
        if (reset) begin
            m   = '{default: 0};
            cnt = 0;
        end else begin
            if (st && !flush && cnt < CMAX) cnt++;
            m = n;
        end
        #1;
        check_regs();
    endtask

    task automatic issue(input bit [4:0] rd, input bit ld,
                         input bit [4:0] ra, input bit [4:0] rb);
        id_valid  = 1;
        id_rd     = rd;
        id_wreg   = 1;
        id_m2reg  = ld;
        id_wmem   = 0;
        id_aluimm = ld;
        id_shift  = 0;
        id_ra     = ra;
        id_rb     = rb;
        id_aluc   = 4'b0000;
        flush     = 0;
        cycle();
    endtask

    // ID presents add r6,r2,r1 (depends on r2).
    task automatic dep_on_r2();
        id_valid  = 1;
        id_rd     = 6;
        id_wreg   = 1;
        id_m2reg  = 0;
        id_wmem   = 0;
        id_aluimm = 0;
        id_shift  = 0;
        id_ra     = 2;
        id_rb     = 1;
        id_qa     = 32'h7;
        id_qb     = 32'h9;
    endtask

    initial begin
        m   = '{default: 0};
        cnt = 0;
        reset = 1;
        id_valid = 1; id_ra = 3; id_rb = 4; id_rd = 5; id_sa = 7;
        id_qa = 32'h1111; id_qb = 32'h2222; id_imm = 32'h3333;
        id_aluimm = 0; id_shift = 0; id_aluc = 4'hF;
        id_wreg = 1; id_m2reg = 1; id_wmem = 1;
        ex_alu_s = 32'h44; mem_rd = 3; mem_wreg = 1; mem_m2reg = 0;
        mem_result = 32'h55; flush = 0;

        #3;
        check_regs();
        chk("reset_stall", stall, 0);
        cycle();
        cycle();
        @(negedge clock);
        reset = 0;
        mem_wreg = 0;
        id_valid = 0;
        #1;
        check_regs();

        // EX forward: add r3 in EX, sub r5,r3,r4 in ID.
        id_qa = 32'h0; id_qb = 32'h0;
        issue(3, 0, 0, 0);
        ex_alu_s = 32'h10;
        id_rd = 5; id_ra = 3; id_rb = 4; id_qa = 32'h1; id_qb = 32'h4;
        id_aluc = 4'b1000;
        #1;
        chk("dir_fwd_a_sel_ex", fwd_a_sel, 2'd1);
        cycle();
        chk("dir_ex_a_fwd", ex_a, 32'h10);
        chk("dir_ex_b", ex_b, 32'h4);
        chk("dir_ex_aluc", ex_aluc, 4'b1000);

        // EX beats MEM on the same register.
        issue(3, 0, 0, 0);
        ex_alu_s = 32'h10;
        mem_wreg = 1; mem_rd = 3; mem_result = 32'h20;
        id_ra = 3; id_rb = 4; id_qa = 32'h1;
        cycle();
        chk("dir_ex_over_mem", ex_a, 32'h10);
        mem_wreg = 0;

        // r0 is never forwarded.
        issue(0, 0, 0, 0);
        ex_alu_s = 32'hFF;
        id_ra = 0; id_rb = 4; id_qa = 32'h55;
        #1;
        chk("dir_r0_sel", fwd_a_sel, 2'd0);
        cycle();
        chk("dir_r0_a", ex_a, 32'h55);

        // Load-use: one bubble, then MEM forward.
        issue(2, 1, 0, 0);
        dep_on_r2();
        #1;
        chk("dir_lu_stall", stall, 1);
        cycle();
        chk("dir_lu_bubble", ex_valid, 0);
        chk("dir_lu_count", stall_count, 1);
        mem_wreg = 1; mem_rd = 2; mem_m2reg = 1; mem_result = 32'hABCD;
        #1;
        chk("dir_lu_nostall", stall, 0);
        chk("dir_lu_sel", fwd_a_sel, 2'd2);
        cycle();
        chk("dir_lu_a", ex_a, 32'hABCD);
        mem_wreg = 0; mem_m2reg = 0;

        // Shift: ra is unused, so a load on it does not stall.
        issue(9, 1, 0, 0);
        id_valid = 1; id_shift = 1; id_aluimm = 0; id_ra = 9; id_rb = 7;
        id_qb = 32'h3; id_sa = 4; id_aluc = 4'b0001; id_rd = 8;
        #1;
        chk("dir_shift_nostall", stall, 0);
        cycle();
        chk("dir_shift_a", ex_a, 32'h3);
        chk("dir_shift_b", ex_b, 32'h4);
        id_shift = 0;

        // Flush overrides stall.
        issue(2, 1, 0, 0);
        dep_on_r2();
        flush = 1;
        cycle();
        chk("dir_flush_bubble", ex_valid, 0);
        chk("dir_flush_count", stall_count, 1);
        flush = 0;

        // Reset while stalling.
        issue(2, 1, 0, 0);
        dep_on_r2();
        #1;
        chk("dir_rs_stall", stall, 1);
        reset = 1;
        #1;
        m   = '{default: 0};
        cnt = 0;
        chk("dir_rs_valid", ex_valid, 0);
        chk("dir_rs_nostall", stall, 0);
        chk("dir_rs_count", stall_count, 0);
        #1;
        reset = 0;

        // Saturation of the stall counter.
        for (int i = 0; i < CMAX + 4; i++) begin
            issue(2, 1, 0, 0);
            dep_on_r2();
            cycle();
        end
        chk("dir_sat", stall_count, CMAX);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            id_valid   = ($urandom_range(9) < 8);
            id_ra      = 5'($urandom_range(3));
            id_rb      = 5'($urandom_range(3));
            id_rd      = 5'($urandom_range(3));
            id_qa      = $urandom;
            id_qb      = $urandom;
            id_imm     = $urandom;
            id_sa      = 5'($urandom);
            id_aluimm  = 1'($urandom);
            id_shift   = ($urandom_range(3) == 0);
            id_aluc    = 4'($urandom);
            id_wreg    = 1'($urandom);
            id_m2reg   = 1'($urandom);
            id_wmem    = ($urandom_range(3) == 0);
            ex_alu_s   = $urandom;
            mem_rd     = 5'($urandom_range(3));
            mem_wreg   = 1'($urandom);
            mem_m2reg  = 1'($urandom);
            mem_result = $urandom;
            flush      = ($urandom_range(9) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
